// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, requests words from instruction memory and fills the IF/ID slot via a one-entry skid.
// Optional macro IFU_PERF_COUNTERS_EN adds fetch/bubble counter ports.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        Stall_In,
  input  logic        Redirect_In,
  input  logic [31:0] Target_In,
  output logic        IMem_Req_Out,
  output logic [31:0] IMem_Addr_Out,
  input  logic        IMem_Ready_In,
  input  logic [31:0] IMem_Data_In,
  output logic [31:0] Instruction_Out,
  output logic [31:0] PCPlus4_Out,
  output logic        Valid_Out
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0] Fetch_Count_Out,
  output logic [31:0] Bubble_Count_Out
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_addr_q;
  logic [31:0] w_addr_nxt;
  logic [31:0] r_skid_instr;
  logic [31:0] w_skid_instr_nxt;
  logic [31:0] r_skid_pc4;
  logic [31:0] w_skid_pc4_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_pc4;
  logic [31:0] w_pc4_nxt;
  logic        r_valid;
  logic        w_valid_nxt;

  logic        w_req;
  logic        w_hs;
  logic        w_consume;
  logic        w_slot_free;
  logic [31:0] w_addr_inc;
  logic [31:0] w_target;

  function automatic logic [31:0] f_word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  assign w_req       = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_hs        = w_req && IMem_Ready_In;
  assign w_consume   = r_valid && !Stall_In;
  assign w_slot_free = !r_valid || !Stall_In;
  assign w_addr_inc  = r_addr_q + 32'd4;
  assign w_target    = f_word_align(Target_In);

  assign IMem_Req_Out    = w_req;
  assign IMem_Addr_Out   = r_addr_q;
  assign Instruction_Out = r_instr;
  assign PCPlus4_Out     = r_pc4;
  assign Valid_Out       = r_valid;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_addr_nxt       = r_addr_q;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc4_nxt   = r_skid_pc4;
    w_instr_nxt      = r_instr;
    w_pc4_nxt        = r_pc4;
    w_valid_nxt      = r_valid;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        w_addr_nxt  = r_pc;
      end

      S_FETCH: begin
        if (Redirect_In) begin
          w_pc_nxt    = w_target;
          w_valid_nxt = 1'b0;
          w_instr_nxt = 32'd0;
          if (w_hs) begin
            w_addr_nxt = w_target;
          end else begin
            // The memory still owes a word for r_addr_q; it must be absorbed first.
            w_state_nxt = S_DRAIN;
          end
        end else if (w_hs) begin
          w_pc_nxt = w_addr_inc;
          if (w_slot_free) begin
            w_instr_nxt = IMem_Data_In;
            w_pc4_nxt   = w_addr_inc;
            w_valid_nxt = 1'b1;
            w_addr_nxt  = w_addr_inc;
          end else begin
            w_skid_instr_nxt = IMem_Data_In;
            w_skid_pc4_nxt   = w_addr_inc;
            w_state_nxt      = S_HOLD;
          end
        end else if (w_consume) begin
          w_valid_nxt = 1'b0;
        end
      end

      S_HOLD: begin
        if (Redirect_In) begin
          w_pc_nxt         = w_target;
          w_addr_nxt       = w_target;
          w_valid_nxt      = 1'b0;
          w_instr_nxt      = 32'd0;
          w_skid_instr_nxt = 32'd0;
          w_skid_pc4_nxt   = 32'd0;
          w_state_nxt      = S_FETCH;
        end else if (!Stall_In) begin
          w_instr_nxt = r_skid_instr;
          w_pc4_nxt   = r_skid_pc4;
          w_valid_nxt = 1'b1;
          w_addr_nxt  = r_pc;
          w_state_nxt = S_FETCH;
        end
      end

      S_DRAIN: begin
        if (Redirect_In) begin
          w_pc_nxt    = w_target;
          w_valid_nxt = 1'b0;
          w_instr_nxt = 32'd0;
        end
        // Returned word is dropped; a same-cycle redirect wins over the stored PC.
        if (w_hs) begin
          w_addr_nxt  = Redirect_In ? w_target : r_pc;
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_addr_q     <= 32'd0;
      r_skid_instr <= 32'd0;
      r_skid_pc4   <= 32'd0;
      r_instr      <= 32'd0;
      r_pc4        <= 32'd0;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_addr_q     <= w_addr_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc4   <= w_skid_pc4_nxt;
      r_instr      <= w_instr_nxt;
      r_pc4        <= w_pc4_nxt;
      r_valid      <= w_valid_nxt;
    end
  end

`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_fetch_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else begin
      if (w_consume) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (!r_valid && (r_state != S_IDLE)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign Fetch_Count_Out  = r_fetch_cnt;
  assign Bubble_Count_Out = r_bubble_cnt;
`endif

endmodule
